// File: rtl/if_stage_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package if_stage_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // addi x0,x0,0 -- the canonical bubble encoding.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Clears the byte offset so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise bubble.
module if_id_pipe_reg #(
  parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_ir,
  input  logic [31:0] load_pc,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic        if_id_valid_inst
);

  // Register update; PC/NPC are left untouched by flush and bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_IR         <= NOP_INST;
      if_id_PC         <= 32'h0000_0000;
      if_id_NPC        <= 32'h0000_0000;
      if_id_valid_inst <= 1'b0;
    end else if (flush) begin
      if_id_IR         <= NOP_INST;
      if_id_valid_inst <= 1'b0;
    end else if (hold) begin
      if_id_IR         <= if_id_IR;
      if_id_valid_inst <= if_id_valid_inst;
    end else if (load) begin
      if_id_IR         <= load_ir;
      if_id_PC         <= load_pc;
      if_id_NPC        <= load_pc + 32'd4;
      if_id_valid_inst <= 1'b1;
    end else begin
      if_id_IR         <= NOP_INST;
      if_id_valid_inst <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage_chk.sv
// Protocol checker for the fetch stage's instruction-memory interface.
module if_stage_chk
  import if_stage_pkg::*;
(
  input logic         clk,
  input logic         rst,
  input fetch_state_e state,
  input logic         imem_req,
  input logic         imem_rvalid
);

  logic abandoned_r;

  // Remembers a request orphaned by reset so its late response is tolerated once.
  always_ff @(posedge clk) begin
    if (imem_rvalid) begin
      abandoned_r <= 1'b0;
    end else if (rst) begin
      abandoned_r <= abandoned_r | (state == WAIT) | (state == DRAIN);
    end else begin
      abandoned_r <= abandoned_r;
    end
  end

  a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> ((state == WAIT) || (state == DRAIN) || abandoned_r))
    else $error("if_stage: imem_rvalid with no request outstanding");

  a_req_only_in_fetch: assert property (@(posedge clk) disable iff (rst)
    imem_req |-> (state == FETCH))
    else $error("if_stage: imem_req outside FETCH");

endmodule

// File: rtl/if_stage.sv
// RV32 instruction fetch stage: owns the PC, keeps one imem request in flight,
// buffers a response during a decode stall and squashes wrong-path fetches.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_hazard_flag,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic        if_id_valid_inst
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  fetch_pc_r;
  logic [31:0]  buf_ir_r;
  logic [31:0]  buf_pc_r;

  logic         accept_s;
  logic         rsp_load_s;
  logic         rsp_buf_s;
  logic         buf_load_s;
  logic         load_s;
  logic [31:0]  load_ir_s;
  logic [31:0]  load_pc_s;
  logic [31:0]  target_s;

  assign imem_addr = pc_r;
  assign target_s  = word_align(ex_target_pc);
  assign load_s    = rsp_load_s | buf_load_s;
  assign load_ir_s = buf_load_s ? buf_ir_r : imem_rdata;
  assign load_pc_s = buf_load_s ? buf_pc_r : fetch_pc_r;

  // Per-state event strobes; a redirect suppresses every other event.
  always_comb begin
    imem_req   = 1'b0;
    accept_s   = 1'b0;
    rsp_load_s = 1'b0;
    rsp_buf_s  = 1'b0;
    buf_load_s = 1'b0;
    if (rst) begin
      imem_req = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          imem_req = ~ex_take_branch;
          accept_s = ~ex_take_branch & imem_ready;
        end
        WAIT: begin
          rsp_load_s = imem_rvalid & ~ex_take_branch & ~id_hazard_flag;
          rsp_buf_s  = imem_rvalid & ~ex_take_branch & id_hazard_flag;
        end
        HOLD: begin
          buf_load_s = ~ex_take_branch & ~id_hazard_flag;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  // Fetch sequencer: PC, in-flight address, stall buffer and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      fetch_pc_r <= 32'h0000_0000;
      buf_ir_r   <= 32'h0000_0000;
      buf_pc_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        FETCH: begin
          if (ex_take_branch) begin
            pc_r <= target_s;
          end else if (accept_s) begin
            fetch_pc_r <= pc_r;
            pc_r       <= pc_r + 32'd4;
            state_r    <= WAIT;
          end
        end
        WAIT: begin
          if (ex_take_branch) begin
            pc_r    <= target_s;
            state_r <= imem_rvalid ? FETCH : DRAIN;
          end else if (rsp_buf_s) begin
            buf_ir_r <= imem_rdata;
            buf_pc_r <= fetch_pc_r;
            state_r  <= HOLD;
          end else if (rsp_load_s) begin
            state_r <= FETCH;
          end
        end
        DRAIN: begin
          if (ex_take_branch) begin
            pc_r <= target_s;
          end
          if (imem_rvalid) begin
            state_r <= FETCH;
          end
        end
        HOLD: begin
          if (ex_take_branch) begin
            pc_r    <= target_s;
            state_r <= FETCH;
          end else if (buf_load_s) begin
            state_r <= FETCH;
          end
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

  if_id_pipe_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id (
    .clk             (clk),
    .rst             (rst),
    .flush           (ex_take_branch),
    .hold            (id_hazard_flag),
    .load            (load_s),
    .load_ir         (load_ir_s),
    .load_pc         (load_pc_s),
    .if_id_IR        (if_id_IR),
    .if_id_PC        (if_id_PC),
    .if_id_NPC       (if_id_NPC),
    .if_id_valid_inst(if_id_valid_inst)
  );

  if_stage_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .state      (state_r),
    .imem_req   (imem_req),
    .imem_rvalid(imem_rvalid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a transaction-level fetch model.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_hazard_flag = 1'b0;
  logic        ex_take_branch = 1'b0;
  logic [31:0] ex_target_pc = 32'h0000_0000;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic [31:0] if_id_NPC;
  logic        if_id_valid_inst;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .id_hazard_flag(id_hazard_flag),
    .ex_take_branch(ex_take_branch), .ex_target_pc(ex_target_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_IR(if_id_IR), .if_id_PC(if_id_PC), .if_id_NPC(if_id_NPC),
    .if_id_valid_inst(if_id_valid_inst)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h0010_8113;
      32'h0000_0008: mem_word = 32'h0020_81B3;
      default:       mem_word = 32'hDEAD_0000 | {16'h0000, a[15:0]};
    endcase
  endfunction

  // Memory responder state.
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  int          lat = 1;
  logic [31:0] mem_addr = 32'h0000_0000;
  bit          acc;
  logic [31:0] acc_addr;

  // Model: live requests, squash mark, stall buffer, program counter, expected IF/ID.
  logic [31:0] q_addr[$];
  bit          m_squash = 1'b0;
  bit          m_buf_v = 1'b0;
  logic [31:0] m_buf_ir = 32'h0;
  logic [31:0] m_buf_pc = 32'h0;
  logic [31:0] m_pc = RESET_PC;
  bit          m_req = 1'b0;
  logic [31:0] e_ir = NOP_INST;
  logic [31:0] e_pc = 32'h0;
  logic [31:0] e_npc = 32'h0;
  bit          e_v = 1'b0;

  task automatic model_step();
    logic [31:0] rsp_addr;
    bit got;
    got = 1'b0;
    rsp_addr = 32'h0;
    if (rst) begin
      m_pc = RESET_PC; q_addr.delete(); m_squash = 1'b0; m_buf_v = 1'b0;
      e_ir = NOP_INST; e_pc = 32'h0; e_npc = 32'h0; e_v = 1'b0;
    end else begin
      if (imem_rvalid && q_addr.size() > 0) begin
        rsp_addr = q_addr.pop_front();
        got = !m_squash && !ex_take_branch;
        m_squash = 1'b0;
      end
      if (ex_take_branch) begin
        m_pc = ex_target_pc & 32'hFFFF_FFFC;
        if (q_addr.size() > 0) m_squash = 1'b1;
        m_buf_v = 1'b0;
        e_ir = NOP_INST; e_v = 1'b0;
      end else begin
        if (m_req && imem_ready) begin
          q_addr.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        if (id_hazard_flag) begin
          if (got) begin
            m_buf_v = 1'b1; m_buf_ir = mem_word(rsp_addr); m_buf_pc = rsp_addr;
          end
        end else if (m_buf_v) begin
          e_ir = m_buf_ir; e_pc = m_buf_pc; e_npc = m_buf_pc + 32'd4; e_v = 1'b1;
          m_buf_v = 1'b0;
        end else if (got) begin
          e_ir = mem_word(rsp_addr); e_pc = rsp_addr; e_npc = rsp_addr + 32'd4; e_v = 1'b1;
        end else begin
          e_ir = NOP_INST; e_v = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive memory, check request, advance model, check IF/ID.
  task automatic cycle();
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(mem_addr); mem_busy = 1'b0;
      end else begin
        imem_rvalid = 1'b0; imem_rdata = 32'hBAD0_BAD0;
      end
    end else begin
      imem_rvalid = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    end
    imem_ready = !mem_busy;
    m_req = !rst && (q_addr.size() == 0) && !m_buf_v && !ex_take_branch;
    #1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_pc);
    acc = imem_req && imem_ready;
    acc_addr = imem_addr;
    @(posedge clk);
    model_step();
    if (acc) begin
      mem_busy = 1'b1; mem_cnt = lat; mem_addr = acc_addr;
    end
    @(negedge clk);
    chk("if_id_IR", if_id_IR, e_ir);
    chk("if_id_PC", if_id_PC, e_pc);
    chk("if_id_NPC", if_id_NPC, e_npc);
    chk("if_id_valid", {31'd0, if_id_valid_inst}, {31'd0, e_v});
  endtask

  task automatic pin(input string name, input logic [31:0] ir, input logic [31:0] pc,
                     input logic [31:0] npc, input logic v);
    chk({name, "_ir"}, if_id_IR, ir);
    chk({name, "_pc"}, if_id_PC, pc);
    chk({name, "_npc"}, if_id_NPC, npc);
    chk({name, "_v"}, {31'd0, if_id_valid_inst}, {31'd0, v});
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    for (int i = 0; i < 2; i++) cycle();
    pin("reset", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // Straight-line fetch, 1-cycle memory
    cycle();
    cycle();
    pin("line0", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
    cycle();
    chk("cadence_bubble_v", {31'd0, if_id_valid_inst}, 32'd0);
    cycle();
    pin("line1", 32'h0010_8113, 32'h4, 32'h8, 1'b1);

    // Stall while the response for PC 8 returns
    cycle();
    id_hazard_flag = 1'b1;
    cycle();
    cycle();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    cycle();
    pin("stall_hold", 32'h0000_0013, 32'h4, 32'h8, 1'b0);
    id_hazard_flag = 1'b0;
    cycle();
    pin("stall_release", 32'h0020_81B3, 32'h8, 32'hC, 1'b1);

    // Redirect while the fetch of 0x10 is outstanding
    cycle();
    cycle();
    lat = 3;
    cycle();
    ex_take_branch = 1'b1; ex_target_pc = 32'h0000_0040;
    cycle();
    pin("wait_redirect", 32'h0000_0013, 32'hC, 32'h10, 1'b0);
    ex_take_branch = 1'b0; lat = 1;
    cycle();
    cycle();
    chk("drain_done_req", {31'd0, imem_req}, 32'd1);
    chk("drain_done_addr", imem_addr, 32'h0000_0040);

    // Redirect coincident with the response (unaligned target)
    cycle();
    ex_take_branch = 1'b1; ex_target_pc = 32'h0000_0083;
    cycle();
    ex_take_branch = 1'b0;
    #1;
    chk("same_cycle_addr", imem_addr, 32'h0000_0080);
    chk("same_cycle_req", {31'd0, imem_req}, 32'd1);
    cycle();
    cycle();
    pin("after_80", 32'hDEAD_0080, 32'h80, 32'h84, 1'b1);

    // Redirect during a stall with PC 0x20 buffered
    ex_take_branch = 1'b1; ex_target_pc = 32'h0000_0020;
    cycle();
    ex_take_branch = 1'b0;
    cycle();
    id_hazard_flag = 1'b1;
    cycle();
    ex_take_branch = 1'b1; ex_target_pc = 32'h0000_0100;
    cycle();
    pin("hold_redirect", 32'h0000_0013, 32'h80, 32'h84, 1'b0);
    ex_take_branch = 1'b0; id_hazard_flag = 1'b0;
    cycle();
    cycle();
    pin("after_100", 32'hDEAD_0100, 32'h100, 32'h104, 1'b1);

    // Address wrap at the top of memory
    ex_take_branch = 1'b1; ex_target_pc = 32'hFFFF_FFFE;
    cycle();
    ex_take_branch = 1'b0;
    cycle();
    cycle();
    pin("wrap", 32'hDEAD_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Reset with a request in flight; its late response must be ignored
    lat = 3;
    cycle();
    rst = 1'b1;
    cycle();
    pin("midreset", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
    chk("midreset_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0; lat = 1;
    cycle();
    cycle();
    chk("late_rsp_ignored_v", {31'd0, if_id_valid_inst}, 32'd0);
    cycle();
    pin("post_reset", 32'h0050_0093, 32'h0, 32'h4, 1'b1);

    for (int i = 0; i < 3; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
